ms_flood_fill: RTL

Sequential, parametrised minesweeper open-cell engine for an arbitrary ROWS x COLS board. One click is accepted; the engine opens the clicked cell. If that cell has zero neighbouring mines, it iteratively flood-opens the 8-neighbourhood of every open zero cell, one dilation step per clock, until nothing changes. It sits between the input/click controller and the board state registers and reports a mine hit and the iteration count.

---
 rtl/ms_flood_fill.sv | 72 +++++++
 1 files changed

// File: rtl/ms_flood_fill.sv
// ms_flood_fill: minesweeper open-cell engine with iterative 8-neighbour flood opening
module ms_flood_fill #(
  parameter  int COLS = 8,
  parameter  int ROWS = 8,
  localparam int N    = ROWS * COLS,
  localparam int IW   = $clog2(N),
  localparam int CW   = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [IW-1:0] click_idx,
  input  logic [N-1:0]  mine,
  input  logic [N-1:0]  zero,
  input  logic [N-1:0]  flag,
  input  logic [N-1:0]  doubt,
  input  logic [N-1:0]  open_in,
  output logic [N-1:0]  open_out,
  output logic          busy,
  output logic          done,
  output logic          hit_mine,
  output logic [CW-1:0] iter_count
);
  localparam logic [1:0] IDLE = 2'd0, SEED = 2'd1, SPREAD = 2'd2, DONE = 2'd3;
  logic [1:0]   state;
  logic [N-1:0] frontier, check, should_open;
  logic         blocked;
  assign frontier    = open_out & zero & ~mine;
  assign should_open = check & ~open_out & ~flag & ~doubt & ~mine;
  assign blocked     = 32'(click_idx) >= N || open_out[click_idx] || flag[click_idx] || doubt[click_idx];
  assign busy        = state != IDLE;
  assign done        = state == DONE;
  // one-step 8-neighbour dilation of the frontier, no wrap at board edges
  always_comb begin
    check = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROWS && c + dc >= 0 && c + dc < COLS)
              check[r*COLS+c] = check[r*COLS+c] | frontier[(r+dr)*COLS+c+dc];
  end
  // click acceptance, seed evaluation and per-cycle spreading
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      open_out   <= '0;
      hit_mine   <= 1'b0;
      iter_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          open_out   <= open_in;
          hit_mine   <= 1'b0;
          iter_count <= '0;
          state      <= SEED;
        end
        SEED: begin
          if (!blocked) open_out[click_idx] <= 1'b1;
          if (!blocked && mine[click_idx]) hit_mine <= 1'b1;
          state <= (blocked || mine[click_idx] || !zero[click_idx]) ? DONE : SPREAD;
        end
        SPREAD: begin
          open_out   <= open_out | should_open;
          iter_count <= &iter_count ? iter_count : iter_count + CW'(1);
          if (should_open == '0) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
